// File: rtl/freq_pkg.sv
// Shared definitions for the frequency display stage.
//   - segment codes (active-low, bit0..6 = a..g, bit7 = dp)
//   - conversion FSM state type
//   - helpers: BCD digit -> segment code, and a constant power-of-ten
package freq_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;   // segment g only

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    // Active-low codes for 0-9 with dp off; anything else blanks.
    function automatic logic [7:0] seg_code(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

    // Elaboration-time 10**n; used for the out-of-range threshold.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment decoder.
//   bcd   in  4  digit value 0-9 (codes above 9 show blank)
//   blank in  1  force all segments off (leading-zero blanking)
//   seg   out 8  bit0..6 = a..g, bit7 = dp, active-low
module seg7_decode
    import freq_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [7:0] seg
);

    assign seg = blank ? SEG_BLANK : seg_code(bcd);

endmodule

// File: rtl/freq_display_scan.sv
// Display stage for the gated frequency counter: buffers each completed
// count, converts it to BCD with a sequential shift-add-3 engine, and scans
// an active-low multi-digit 7-segment display with leading-zero blanking
// and dashes for out-of-range values.
//   clck        in   1        system clock, rising edge
//   rst_n       in   1        asynchronous active-low reset
//   count_in    in   COUNT_W  completed gate count, sampled when count_valid=1
//   count_valid in   1        one-cycle pulse marking a new count
//   digit       out  8        digit enables, active-low, bit i = digit i
//   segment     out  8        a..g + dp, active-low; dp always off
//   busy        out  1        conversion engine not idle
//   overflow    out  1        displayed value is out of range (dashes)
module freq_display_scan
    import freq_pkg::*;
#(
    parameter int COUNT_W    = 27,
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000
) (
    input  logic               clck,
    input  logic               rst_n,
    input  logic [COUNT_W-1:0] count_in,
    input  logic               count_valid,
    output logic [7:0]         digit,
    output logic [7:0]         segment,
    output logic               busy,
    output logic               overflow
);

    localparam int          BCD_W = 4 * NUM_DIGITS;
    localparam int          BC_W  = $clog2(COUNT_W);
    localparam int          PS_W  = $clog2(SCAN_DIV);
    localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);

    // Pending input buffer
    logic               pend_val;
    logic [COUNT_W-1:0] pend_cnt;

    // Conversion engine
    conv_state_t        state, state_next;
    logic [COUNT_W-1:0] shift_reg;
    logic [BCD_W-1:0]   bcd, bcd_adj;
    logic [BC_W-1:0]    bit_cnt;
    logic               ovf_t;
    logic               load;
    logic               last_bit;

    // Display registers and scan
    logic [BCD_W-1:0]   disp_bcd;
    logic               disp_ovf;
    logic [PS_W-1:0]    presc;
    logic [2:0]         scan_idx;
    logic [3:0]         cur_nib;
    logic               cur_blank;
    logic [7:0]         dec_seg;

    assign load     = (state == IDLE) && pend_val;
    assign last_bit = (bit_cnt == BC_W'(COUNT_W - 1));
    assign busy     = (state != IDLE);
    assign overflow = disp_ovf;

    // A new valid always wins over consumption so a same-cycle pulse re-arms.
    // NOTE: all clocked state uses non-blocking (<=) so every register sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            pend_val <= 1'b0;
            pend_cnt <= '0;
        end else if (count_valid) begin
            pend_val <= 1'b1;
            pend_cnt <= count_in;
        end else if (load) begin
            pend_val <= 1'b0;
        end
    end

    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pend_val) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Add 3 to every nibble >= 5 before each shift (double dabble).
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bcd       <= '0;
            bit_cnt   <= '0;
            ovf_t     <= 1'b0;
            disp_bcd  <= '0;
            disp_ovf  <= 1'b0;
        end else begin
            if (load) begin
                shift_reg <= pend_cnt;
                bcd       <= '0;
                bit_cnt   <= '0;
                ovf_t     <= ({{(64-COUNT_W){1'b0}}, pend_cnt} >= LIMIT);
            end else if (state == SHIFT) begin
                bcd       <= {bcd_adj[BCD_W-2:0], shift_reg[COUNT_W-1]};
                shift_reg <= shift_reg << 1;
                bit_cnt   <= bit_cnt + 1'b1;
            end
            // Display regs change only here, so a partial result is never shown.
            if (state == COMMIT) begin
                disp_bcd <= bcd;
                disp_ovf <= ovf_t;
            end
        end
    end

    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            scan_idx <= '0;
        end else if (presc == PS_W'(SCAN_DIV - 1)) begin
            presc    <= '0;
            scan_idx <= (scan_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : scan_idx + 3'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Select the current nibble and decide leading-zero blanking: digit i>0
    // blanks when it and every more significant nibble are zero.
    always_comb begin
        logic lead_zero;
        cur_nib   = 4'd0;
        cur_blank = 1'b0;
        lead_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lead_zero = lead_zero && (disp_bcd[4*i +: 4] == 4'd0);
            if (3'(i) == scan_idx) begin
                cur_nib   = disp_bcd[4*i +: 4];
                cur_blank = lead_zero && (i != 0);
            end
        end
    end

    seg7_decode u_dec (
        .bcd   (cur_nib),
        .blank (cur_blank),
        .seg   (dec_seg)
    );

    // Outputs are registered one cycle behind the index/data. The first
    // prescaler count of each index drives all digits off to avoid ghosting.
    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            digit   <= 8'hFF;
            segment <= SEG_BLANK;
        end else begin
            digit   <= (presc == '0) ? 8'hFF : ~(8'b1 << scan_idx);
            segment <= disp_ovf ? SEG_DASH : dec_seg;
        end
    end

endmodule

// File: tb/tb_freq_display_scan.sv
// Directed self-checking bench for freq_display_scan. Two instances share
// stimulus: an 8-digit display and a 4-digit one (upper digit lines held off).
module tb_freq_display_scan;

    localparam int COUNT_W  = 27;
    localparam int SCAN_DIV = 4;

    logic               clck = 1'b0;
    logic               rst_n;
    logic [COUNT_W-1:0] count_in;
    logic               count_valid;
    logic [7:0]         digit8, segment8, digit4, segment4;
    logic               busy8, overflow8, busy4, overflow4;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clck = ~clck;

    freq_display_scan #(.COUNT_W(COUNT_W), .NUM_DIGITS(8), .SCAN_DIV(SCAN_DIV)) dut8 (
        .clck(clck), .rst_n(rst_n), .count_in(count_in), .count_valid(count_valid),
        .digit(digit8), .segment(segment8), .busy(busy8), .overflow(overflow8)
    );

    freq_display_scan #(.COUNT_W(COUNT_W), .NUM_DIGITS(4), .SCAN_DIV(SCAN_DIV)) dut4 (
        .clck(clck), .rst_n(rst_n), .count_in(count_in), .count_valid(count_valid),
        .digit(digit4), .segment(segment4), .busy(busy4), .overflow(overflow4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clck);
        #1;
    endtask

    // Wait (bounded) until digit i of the chosen instance is selected, then check its segments.
    task automatic show(input bit use4, input int i, input logic [7:0] exp, input string tag);
        logic [7:0] want;
        int n;
        want = ~(8'b1 << i);
        n = 0;
        while (((use4 ? digit4 : digit8) !== want) && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_sel"}, use4 ? digit4 : digit8, want);
        check(tag, use4 ? segment4 : segment8, exp);
    endtask

    task automatic pulse(input logic [COUNT_W-1:0] v);
        count_in    = v;
        count_valid = 1'b1;
        tick();
        count_valid = 1'b0;
    endtask

    // Pulse a value and wait (bounded) for its conversion to commit.
    task automatic convert(input logic [COUNT_W-1:0] v, input string tag);
        int n;
        pulse(v);
        tick();
        n = 0;
        while (busy8 && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_done"}, busy8, 1'b0);
    endtask

    initial begin
        int n;
        int rises;
        logic prev;
        logic [7:0] exp8, exp4;

        // 1: reset state, then idle display shows "0"
        rst_n = 1'b0; count_in = '0; count_valid = 1'b0;
        repeat (3) tick();
        check("rst_digit8", digit8, 8'hFF);
        check("rst_seg8", segment8, 8'hFF);
        check("rst_busy8", busy8, 1'b0);
        check("rst_ovf8", overflow8, 1'b0);
        check("rst_digit4", digit4, 8'hFF);
        rst_n = 1'b1;
        show(0, 0, 8'hC0, "idle_d0");
        show(0, 1, 8'hFF, "idle_d1");
        show(0, 7, 8'hFF, "idle_d7");

        // 2: 1234, busy length and scanned digits
        pulse(27'd1234);
        check("busy_after_valid", busy8, 1'b0);
        tick();
        n = 0;
        while (busy8 && n < 100) begin
            n++;
            tick();
        end
        check("busy_cycles", n, COUNT_W + 1);
        show(0, 0, 8'h99, "n1234_d0");
        show(0, 1, 8'hB0, "n1234_d1");
        show(0, 2, 8'hA4, "n1234_d2");
        show(0, 3, 8'hF9, "n1234_d3");
        show(0, 4, 8'hFF, "n1234_d4");
        show(0, 7, 8'hFF, "n1234_d7");
        show(1, 3, 8'hF9, "n1234_4d_d3");

        // 3: overflow at 10**8, then recovery with 7
        convert(27'd100_000_000, "ovf");
        check("ovf_flag8", overflow8, 1'b1);
        check("ovf_flag4", overflow4, 1'b1);
        show(0, 0, 8'hBF, "ovf_d0");
        show(0, 3, 8'hBF, "ovf_d3");
        show(0, 7, 8'hBF, "ovf_d7");
        convert(27'd99_999_999, "max");
        check("max_ovf8", overflow8, 1'b0);
        check("max_ovf4", overflow4, 1'b1);
        show(0, 7, 8'h90, "max_d7");
        convert(27'd7, "seven");
        check("seven_ovf", overflow8, 1'b0);
        show(0, 0, 8'hF8, "seven_d0");
        show(0, 1, 8'hFF, "seven_d1");

        // 4: overwrites during SHIFT -> exactly one extra conversion, ends at 666
        pulse(27'd4321);
        repeat (6) tick();
        check("mid_busy", busy8, 1'b1);
        pulse(27'd555);
        tick();
        pulse(27'd666);
        rises = 0;
        prev  = busy8;
        for (int k = 0; k < 150; k++) begin
            tick();
            if (busy8 && !prev) rises++;
            prev = busy8;
        end
        check("extra_convs", rises, 1);
        check("last_idle", busy8, 1'b0);
        show(0, 0, 8'h82, "n666_d0");
        show(0, 1, 8'h82, "n666_d1");
        show(0, 2, 8'h82, "n666_d2");
        show(0, 3, 8'hFF, "n666_d3");

        // 5: reset mid-conversion of 9999 over a displayed 42
        convert(27'd42, "n42");
        show(0, 0, 8'hA4, "n42_d0");
        show(0, 1, 8'h99, "n42_d1");
        pulse(27'd9999);
        repeat (8) tick();
        check("abort_busy_pre", busy8, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_digit", digit8, 8'hFF);
        check("abort_seg", segment8, 8'hFF);
        check("abort_busy", busy8, 1'b0);
        check("abort_ovf", overflow8, 1'b0);
        tick();
        rst_n = 1'b1;
        rises = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (busy8) rises++;
        end
        check("abort_no_conv", rises, 0);
        show(0, 0, 8'hC0, "abort_d0");
        show(0, 1, 8'hFF, "abort_d1");
        show(0, 3, 8'hFF, "abort_d3");

        // 6: scan timing on both instances (aligned since the last reset)
        n = 0;
        while (digit8 !== 8'hFE && n < 200) begin
            tick();
            n++;
        end
        check("scan_sync", digit8, 8'hFE);
        // Seen FE => prescaler position 1 of index 0.
        for (int j = 0; j < 40; j++) begin
            int t;
            t = j + 1;
            exp8 = ((t % SCAN_DIV) == 0) ? 8'hFF : ~(8'b1 << ((t / SCAN_DIV) % 8));
            exp4 = ((t % SCAN_DIV) == 0) ? 8'hFF : ~(8'b1 << ((t / SCAN_DIV) % 4));
            check($sformatf("scan8_t%0d", t), digit8, exp8);
            check($sformatf("scan4_t%0d", t), digit4, exp4);
            check($sformatf("scan4_hi_t%0d", t), digit4[7:4], 4'hF);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
